md_unit: RTL and testbench
==========================

# md_unit

Multi-cycle multiply/divide unit for the E stage of the five-stage MIPS pipeline. Operands come from the forwarded rs/rt values of the instruction in E. The unit owns the HI and LO registers. It reports a busy flag that the hazard unit uses to stall any HI/LO-dependent instruction held in D. MFHI/MFLO read the `hi`/`lo` outputs combinationally and carry the result down the pipeline like an ALU result.

## Interface
- `MULT_LAT`, default 5: busy cycles for MULT/MULTU (and MADD/MADDU when enabled).
- `DIV_LAT`, default 10: busy cycles for DIV/DIVU.
- `clk` input 1: clock; every register updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: a new operation is presented this cycle. Only asserted for the instruction in E, never for a flushed bubble.
- `md_op` input 3: operation code, defined in the shared package. Codes: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MADD, MD_MADDU.
- `src_a` input 32: forwarded rs value.
- `src_b` input 32: forwarded rt value.
- `busy` output 1: a multi-cycle operation is in flight.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1; a down-counter holds the remaining cycles.
  - In RUN the pending result is held in internal registers `res_hi`/`res_lo`.
- IDLE with `start`=1 and a MULT/MULTU/DIV/DIVU op:
  - Latch the result computed from `src_a`/`src_b`.
  - Load the counter with the matching latency.
  - Go to RUN.
- IDLE with `start`=1 and MTHI/MTLO: write `src_a` into `hi` (MTHI) or `lo` (MTLO) on the same edge. Stay in IDLE.
- RUN: decrement the counter each cycle. At count 1, copy `res_hi`/`res_lo` to `hi`/`lo` and return to IDLE.
- `start` while in RUN is ignored. The hazard unit guarantees this never happens: it stalls on `busy | start` for any md instruction or MFHI/MFLO in D.
- Arithmetic:
  - MULT: signed 32×32→64; `hi` = bits 63:32, `lo` = bits 31:0.
  - MULTU: the same, unsigned.
  - DIV: signed; `lo` = quotient truncated toward zero, `hi` = remainder with the sign of the dividend.
  - DIVU: the same, unsigned.
- Division by zero: the operation still occupies `DIV_LAT` busy cycles, and `hi`/`lo` stay unchanged.
- Signed DIV of 0x80000000 by 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- Undefined `md_op` with `start`: no effect.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0, counter=0, state IDLE. An assertion mid-operation aborts the operation with no HI/LO update.
- `start` sampled at edge t:
  - `busy`=1 from cycle t+1 through cycle t+N (N = `MULT_LAT` or `DIV_LAT`).
  - `hi`/`lo` show the new value from cycle t+N+1, the same cycle `busy` falls.
- MTHI/MTLO sampled at edge t: the new value is visible at cycle t+1; `busy` stays 0.
- Back-to-back: a `start` in the first IDLE cycle after RUN is accepted normally.
- `hi`/`lo` are stable for the whole RUN period. An MFHI in flight after the md instruction never sees a partial value.

## Configuration
- `MD_MADD_EN` defined:
  - MD_MADD/MD_MADDU are accepted.
  - The result is {hi,lo} + src_a×src_b (signed or unsigned product), wrapping modulo 2^64.
  - `{hi,lo}` is sampled at start and the latency is `MULT_LAT`.
- `MD_MADD_EN` not defined: MD_MADD/MD_MADDU are treated as undefined ops with no effect, and the accumulate datapath is not synthesised.

## Structure
- Shared package (alongside the existing opcode/field constants):
  - `md_op` codes.
  - Default latencies.
  - The 6-bit funct values for MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO, plus MADD/MADDU under special2.
- Controller change: decode `start`, `md_op` and the hazard stall term from those constants.
- No sub-module. Results use behavioural `*`, `/` and `%` at start; the counter models the latency.

## Test plan
- MULT 0xFFFFFFFE × 3 (−2×3), start at cycle 0 → `busy` high cycles 1–5; cycle 6: `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001, after exactly 5 busy cycles.
- DIV −7 / 2 → `busy` for 10 cycles; then `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 7/0 with prior hi=0x11, lo=0x22 → values unchanged after 10 busy cycles.
- MTLO 0x1234 at cycle 0 → `lo`=0x1234 at cycle 1, `busy` never rises. `start` MULT asserted during RUN → ignored, first result intact.
- `reset` pulsed at busy cycle 3 of a DIV → `busy`, `hi`, `lo` all 0 immediately; no later update.
- With `MD_MADD_EN`: hi=0, lo=0xFFFFFFFF, then MADDU 1×1 → `hi`=1, `lo`=0. Without the macro: same stimulus → `hi`/`lo` unchanged and `busy` stays 0.

Source files
------------

// File: rtl/md_unit_pkg.sv
// Shared constants for the E-stage multiply/divide unit: md_op codes, default
// latencies and the MIPS funct/opcode values the controller decodes into md_op.
package md_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MADD  = 3'd6,
        MD_MADDU = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MD_MULT_LAT_DEF = 5;
    localparam int MD_DIV_LAT_DEF  = 10;

    localparam logic [5:0] OPCODE_SPECIAL  = 6'h00;
    localparam logic [5:0] OPCODE_SPECIAL2 = 6'h1C;

    // SPECIAL funct field
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    // SPECIAL2 funct field
    localparam logic [5:0] FUNCT_MADD  = 6'h00;
    localparam logic [5:0] FUNCT_MADDU = 6'h01;

    // True for SPECIAL functs that read or write HI/LO (used for the stall term).
    function automatic logic is_hilo_funct(input logic [5:0] funct);
        return (funct == FUNCT_MFHI) || (funct == FUNCT_MTHI) ||
               (funct == FUNCT_MFLO) || (funct == FUNCT_MTLO) ||
               (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
               (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; result computed at start, counter models latency.
// Optional multiply-accumulate (MADD/MADDU) is built only when MD_MADD_EN is defined.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_LAT = MD_MULT_LAT_DEF,
    parameter int DIV_LAT  = MD_DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    md_state_e        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [31:0]      hi_reg, hi_next;
    logic [31:0]      lo_reg, lo_next;
    logic [31:0]      res_hi_reg, res_hi_next;
    logic [31:0]      res_lo_reg, res_lo_next;
    md_op_e           op;

    assign op = md_op_e'(md_op);

    // Products
    logic [63:0] prod_s, prod_u;
    assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
    assign prod_u = {32'd0, src_a} * {32'd0, src_b};

    // Division: divisor forced to 1 on zero so the datapath never sees x.
    // Signed divide works on magnitudes, which yields 0x80000000 / -1 = 0x80000000 r 0.
    logic        div_zero;
    logic [31:0] divisor_u, quo_u, rem_u;
    logic [31:0] mag_a, mag_b, quo_mag, rem_mag, quo_s, rem_s;

    assign div_zero  = (src_b == 32'd0);
    assign divisor_u = div_zero ? 32'd1 : src_b;
    assign quo_u     = src_a / divisor_u;
    assign rem_u     = src_a % divisor_u;
    assign mag_a     = src_a[31] ? (~src_a + 32'd1) : src_a;
    assign mag_b     = src_b[31] ? (~src_b + 32'd1) : divisor_u;
    assign quo_mag   = mag_a / mag_b;
    assign rem_mag   = mag_a % mag_b;
    assign quo_s     = (src_a[31] ^ src_b[31]) ? (~quo_mag + 32'd1) : quo_mag;
    assign rem_s     = src_a[31] ? (~rem_mag + 32'd1) : rem_mag;

`ifdef MD_MADD_EN
    logic [63:0] acc_s, acc_u;
    assign acc_s = {hi_reg, lo_reg} + prod_s;
    assign acc_u = {hi_reg, lo_reg} + prod_u;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            res_hi_reg <= '0;
            res_lo_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            res_hi_reg <= res_hi_next;
            res_lo_reg <= res_lo_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        res_hi_next = res_hi_reg;
        res_lo_next = res_lo_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        MD_MULT: begin
                            {res_hi_next, res_lo_next} = prod_s;
                            cnt_next   = MULT_CNT;
                            state_next = ST_RUN;
                        end
                        MD_MULTU: begin
                            {res_hi_next, res_lo_next} = prod_u;
                            cnt_next   = MULT_CNT;
                            state_next = ST_RUN;
                        end
                        MD_DIV: begin
                            // Divide by zero still runs the full latency but commits HI/LO unchanged.
                            res_hi_next = div_zero ? hi_reg : rem_s;
                            res_lo_next = div_zero ? lo_reg : quo_s;
                            cnt_next    = DIV_CNT;
                            state_next  = ST_RUN;
                        end
                        MD_DIVU: begin
                            res_hi_next = div_zero ? hi_reg : rem_u;
                            res_lo_next = div_zero ? lo_reg : quo_u;
                            cnt_next    = DIV_CNT;
                            state_next  = ST_RUN;
                        end
                        MD_MTHI: hi_next = src_a;
                        MD_MTLO: lo_next = src_a;
`ifdef MD_MADD_EN
                        MD_MADD: begin
                            {res_hi_next, res_lo_next} = acc_s;
                            cnt_next   = MULT_CNT;
                            state_next = ST_RUN;
                        end
                        MD_MADDU: begin
                            {res_hi_next, res_lo_next} = acc_u;
                            cnt_next   = MULT_CNT;
                            state_next = ST_RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_next = cnt_reg - CNT_ONE;
                if (cnt_reg == CNT_ONE) begin
                    hi_next    = res_hi_reg;
                    lo_next    = res_lo_reg;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy = (state_reg == ST_RUN);
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed operations with literal expectations plus a
// cycle-by-cycle comparison against an arithmetic model of HI/LO and busy.
module tb_md_unit;
    import md_unit_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    md_op_e      md_op = MD_MULT;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;
    bit run_checks = 0;

    md_unit #(.MULT_LAT(MULT_N), .DIV_LAT(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of an op; returns 0 if the op does not start a busy period.
    function automatic bit model_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [63:0] acc, output logic [63:0] res, output int lat);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        res = acc;
        lat = 0;
        case (op)
            MD_MULT:  begin res = 64'(sa * sb); lat = MULT_N; end
            MD_MULTU: begin res = ua * ub;      lat = MULT_N; end
            MD_DIV: begin
                lat = DIV_N;
                if (b != 0) begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            MD_DIVU: begin
                lat = DIV_N;
                if (b != 0) res = {32'(ua % ub), 32'(ua / ub)};
            end
`ifdef MD_MADD_EN
            MD_MADD:  begin res = acc + 64'(sa * sb); lat = MULT_N; end
            MD_MADDU: begin res = acc + ua * ub;      lat = MULT_N; end
`endif
            default: ;
        endcase
        return lat != 0;
    endfunction

    // Model: absolute edge index at which a pending result lands in HI/LO.
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_res;
    bit          m_pending = 0;
    int          edge_n = 0, m_done = 0;

    always @(posedge clk or posedge reset) begin
        int lat;
        if (reset) begin
            m_hi = '0;
            m_lo = '0;
            m_pending = 0;
        end else begin
            edge_n++;
            if (m_pending) begin
                if (edge_n == m_done) begin
                    {m_hi, m_lo} = m_res;
                    m_pending = 0;
                end
            end else if (start) begin
                if (md_op == MD_MTHI) m_hi = src_a;
                else if (md_op == MD_MTLO) m_lo = src_a;
                else if (model_op(md_op, src_a, src_b, {m_hi, m_lo}, m_res, lat)) begin
                    m_pending = 1;
                    m_done = edge_n + lat;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (run_checks) begin
            chk("model_busy", {31'd0, busy}, {31'd0, m_pending});
            chk("model_hi", hi, m_hi);
            chk("model_lo", lo, m_lo);
        end
    end

    // Called at a negedge; returns at the negedge of the first idle cycle.
    task automatic issue_wait(input md_op_e op, input logic [31:0] a, input logic [31:0] b, output int n);
        start = 1'b1;
        md_op = op;
        src_a = a;
        src_b = b;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) chk("busy_timeout", 32'(n), 32'd0);
        $display("%-8s a=%h b=%h busy_cycles=%0d hi=%h lo=%h", op.name(), a, b, n, hi, lo);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_checks = 1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);

        issue_wait(MD_MULT, 32'hFFFFFFFE, 32'd3, n);
        chk("mult_busy_cycles", 32'(n), 32'd5);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);

        // Back-to-back: issued in the first idle cycle
        issue_wait(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, n);
        chk("multu_busy_cycles", 32'(n), 32'd5);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);

        issue_wait(MD_DIV, 32'hFFFFFFF9, 32'd2, n);
        chk("div_busy_cycles", 32'(n), 32'd10);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        issue_wait(MD_DIV, 32'd7, 32'hFFFFFFFE, n);
        chk("div_negb_lo", lo, 32'hFFFFFFFD);
        chk("div_negb_hi", hi, 32'h00000001);

        issue_wait(MD_DIV, 32'h80000000, 32'hFFFFFFFF, n);
        chk("div_ovf_lo", lo, 32'h80000000);
        chk("div_ovf_hi", hi, 32'h00000000);

        issue_wait(MD_DIVU, 32'd100, 32'd7, n);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        issue_wait(MD_MTHI, 32'h11, 32'd0, n);
        chk("mthi_busy_cycles", 32'(n), 32'd0);
        issue_wait(MD_MTLO, 32'h22, 32'd0, n);
        issue_wait(MD_DIVU, 32'd7, 32'd0, n);
        chk("div0_busy_cycles", 32'(n), 32'd10);
        chk("div0_hi", hi, 32'h11);
        chk("div0_lo", lo, 32'h22);

        issue_wait(MD_MTLO, 32'h1234, 32'd0, n);
        chk("mtlo_busy_cycles", 32'(n), 32'd0);
        chk("mtlo_lo", lo, 32'h1234);
        chk("mtlo_hi", hi, 32'h11);

        // A start during RUN must be ignored
        start = 1'b1; md_op = MD_MULT; src_a = 32'd6; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; md_op = MD_MULT; src_a = 32'd100; src_b = 32'd100;
        @(negedge clk);
        start = 1'b0;
        n = 2;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        $display("MULT     a=%h b=%h busy_cycles=%0d hi=%h lo=%h (start during run)", 32'd6, 32'd7, n, hi, lo);
        chk("ignore_busy_cycles", 32'(n), 32'd5);
        chk("ignore_lo", lo, 32'd42);
        chk("ignore_hi", hi, 32'd0);

        // Reset during busy cycle 3 of a DIV
        issue_wait(MD_MTHI, 32'h55, 32'd0, n);
        start = 1'b1; md_op = MD_DIV; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        $display("RESET    during DIV busy cycle 3: busy=%b hi=%h lo=%h", busy, hi, lo);
        chk("rst_after_hi", hi, 32'd0);
        chk("rst_after_lo", lo, 32'd0);

        issue_wait(MD_MTHI, 32'd0, 32'd0, n);
        issue_wait(MD_MTLO, 32'hFFFFFFFF, 32'd0, n);
        issue_wait(MD_MADDU, 32'd1, 32'd1, n);
`ifdef MD_MADD_EN
        chk("maddu_busy_cycles", 32'(n), 32'd5);
        chk("maddu_hi", hi, 32'd1);
        chk("maddu_lo", lo, 32'd0);
        issue_wait(MD_MADD, 32'hFFFFFFFF, 32'd1, n);
        chk("madd_hi", hi, 32'd0);
        chk("madd_lo", lo, 32'hFFFFFFFF);
`else
        chk("maddu_busy_cycles", 32'(n), 32'd0);
        chk("maddu_hi", hi, 32'd0);
        chk("maddu_lo", lo, 32'hFFFFFFFF);
`endif

        repeat (2) @(negedge clk);
        run_checks = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
